// File: rtl/lasernet_pkg.sv
// Shared framing definitions for the laser link transmit and receive paths.
package lasernet_pkg;

    localparam logic [7:0]  PREAMBLE   = 8'h55;
    localparam logic [7:0]  SOF        = 8'hD5;
    localparam int unsigned FRAME_BITS = 144;

    // Bit positions inside the 9-bit flags field
    localparam int unsigned FLAG_ACK = 4;
    localparam int unsigned FLAG_SYN = 1;
    localparam int unsigned FLAG_FIN = 0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCapture,
        StCsum,
        StSend,
        StGap,
        StDone
    } tx_state_e;

endpackage

// File: rtl/ones_comp_csum16.sv
// 16-bit ones-complement accumulator; caller inverts the sum to form the checksum.
module ones_comp_csum16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        valid,
    input  logic [15:0] word,
    output logic [15:0] sum
);

    logic [15:0] sum_q;
    logic [15:0] sum_d;
    logic [16:0] raw;

    // Add with end-around carry; a carry-in of 1 can never overflow a second time
    always_comb begin
        raw   = {1'b0, sum_q} + {1'b0, word};
        sum_d = raw[15:0] + {15'b0, raw[16]};
    end

    // Accumulator register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else if (clear) begin
            sum_q <= '0;
        end else if (valid) begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/packet_tx.sv
// Transmit stage: fetch payload, checksum, serialise a 144-bit frame MSB-first, then idle gap.
module packet_tx
    import lasernet_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned BIT_CYCLES = 16,
    parameter int unsigned GAP_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       seq_in,
    input  logic [31:0]       ack_in,
    input  logic [8:0]        flags_in,
    input  logic [31:0]       isn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_data,
    output logic              txbit,
    output logic              txactive,
    output logic              packetsent,
    output logic              busy
);

    localparam int unsigned HOLD_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BIT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [7:0]        BIT_LAST  = 8'(FRAME_BITS - 1);

    tx_state_e state_q, state_d;

    logic [31:0]       seq_q;
    logic [31:0]       ack_q;
    logic [8:0]        flags_q;
    logic [31:0]       isn_q;
    logic [DATA_W-1:0] payload_q;
    logic [2:0]        csum_idx_q;
    logic [7:0]        bit_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [GAP_W-1:0]  gap_cnt_q;

    logic                  is_ctrl;
    logic                  hold_last;
    logic                  bit_last;
    logic                  gap_last;
    logic [31:0]           offset;
    logic [15:0]           csum_word;
    logic [15:0]           csum_sum;
    logic [FRAME_BITS-1:0] frame;
    logic [7:0]            bit_idx;

    assign is_ctrl   = flags_q[FLAG_SYN] | flags_q[FLAG_FIN];
    assign hold_last = (hold_cnt_q == HOLD_LAST);
    assign bit_last  = (bit_cnt_q == BIT_LAST);
    assign gap_last  = (gap_cnt_q == GAP_LAST);
    assign offset    = seq_q - isn_q;

    // State register; reset aborts any frame in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StFetch;
            StFetch:   state_d = StCapture;
            StCapture: state_d = StCsum;
            StCsum:    if (csum_idx_q == 3'd6) state_d = StSend;
            StSend:    if (bit_last && hold_last) state_d = StGap;
            StGap:     if (gap_last) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Request latches, payload capture and the sequencing counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_q      <= '0;
            ack_q      <= '0;
            flags_q    <= '0;
            isn_q      <= '0;
            payload_q  <= '0;
            csum_idx_q <= '0;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    csum_idx_q <= '0;
                    bit_cnt_q  <= '0;
                    hold_cnt_q <= '0;
                    gap_cnt_q  <= '0;
                    if (start) begin
                        seq_q   <= seq_in;
                        ack_q   <= ack_in;
                        flags_q <= flags_in;
                        isn_q   <= isn;
                    end
                end
                StCapture: payload_q <= is_ctrl ? '0 : mem_data;
                StCsum:    csum_idx_q <= csum_idx_q + 3'd1;
                StSend: begin
                    if (hold_last) begin
                        hold_cnt_q <= '0;
                        bit_cnt_q  <= bit_last ? '0 : bit_cnt_q + 8'd1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                StGap:   gap_cnt_q <= gap_last ? '0 : gap_cnt_q + GAP_W'(1);
                default: ;
            endcase
        end
    end

    // One checksum word per CSUM cycle, in frame order
    always_comb begin
        csum_word = '0;
        unique case (csum_idx_q)
            3'd0:    csum_word = seq_q[31:16];
            3'd1:    csum_word = seq_q[15:0];
            3'd2:    csum_word = ack_q[31:16];
            3'd3:    csum_word = ack_q[15:0];
            3'd4:    csum_word = {7'b0, flags_q};
            3'd5:    csum_word = payload_q[31:16];
            3'd6:    csum_word = payload_q[15:0];
            default: csum_word = '0;
        endcase
    end

    ones_comp_csum16 u_csum (
        .clk   (clk),
        .reset (reset),
        .clear (state_q == StFetch),
        .valid (state_q == StCsum),
        .word  (csum_word),
        .sum   (csum_sum)
    );

    // Outputs decode straight from state so an async reset drops them without a clock edge
    always_comb begin
        frame      = {PREAMBLE, SOF, seq_q, ack_q, 7'b0, flags_q, payload_q, ~csum_sum};
        bit_idx    = BIT_LAST - bit_cnt_q;
        busy       = (state_q != StIdle);
        packetsent = (state_q == StDone);
        txactive   = (state_q == StSend);
        txbit      = txactive & frame[bit_idx];
        mem_en     = (state_q == StFetch) & ~is_ctrl;
        mem_addr   = (state_q == StFetch) ? offset[ADDR_W-1:0] : '0;
    end

endmodule

// File: tb/tb_packet_tx.sv
// Directed bench for packet_tx: one instance with 1-cycle bits, one with 16-cycle bits.
module tb_packet_tx;

    localparam logic [143:0] FRAME_DATA =
        {8'h55, 8'hD5, 32'h00000005, 32'h00000003, 16'h0010, 32'h12345678, 16'h973B};

    logic        clk;
    logic        reset;
    logic        start;
    logic        start16;
    logic [31:0] seq_in;
    logic [31:0] ack_in;
    logic [8:0]  flags_in;
    logic [31:0] isn;

    logic [15:0] mem_addr, mem_addr16;
    logic        mem_en, mem_en16;
    logic [31:0] mem_data, mem_data16;
    logic        txbit, txbit16;
    logic        txactive, txactive16;
    logic        packetsent, packetsent16;
    logic        busy, busy16;

    int errors = 0;
    int checks = 0;

    packet_tx #(
        .DATA_W     (32),
        .ADDR_W     (16),
        .BIT_CYCLES (1),
        .GAP_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .seq_in     (seq_in),
        .ack_in     (ack_in),
        .flags_in   (flags_in),
        .isn        (isn),
        .mem_addr   (mem_addr),
        .mem_en     (mem_en),
        .mem_data   (mem_data),
        .txbit      (txbit),
        .txactive   (txactive),
        .packetsent (packetsent),
        .busy       (busy)
    );

    packet_tx #(
        .DATA_W     (32),
        .ADDR_W     (16),
        .BIT_CYCLES (16),
        .GAP_CYCLES (4)
    ) dut16 (
        .clk        (clk),
        .reset      (reset),
        .start      (start16),
        .seq_in     (seq_in),
        .ack_in     (ack_in),
        .flags_in   (flags_in),
        .isn        (isn),
        .mem_addr   (mem_addr16),
        .mem_en     (mem_en16),
        .mem_data   (mem_data16),
        .txbit      (txbit16),
        .txactive   (txactive16),
        .packetsent (packetsent16),
        .busy       (busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return (a == 16'd5) ? 32'h12345678 : {16'hA5A5, a};
    endfunction

    // Synchronous-read memory models, one per instance
    always @(posedge clk) begin
        if (mem_en)   mem_data   <= mem_word(mem_addr);
        if (mem_en16) mem_data16 <= mem_word(mem_addr16);
    end

    // Send one packet on the 1-cycle instance and observe cycles t+1..t+170
    task automatic run_b1(input logic [31:0] s, input logic [31:0] a, input logic [8:0] f,
                          input logic [31:0] i, input bit inject,
                          output logic [15:0] addr1, output logic en1,
                          output logic [143:0] fr, output int act_bad, output int busy_bad,
                          output int sent_at, output int sent_cnt);
        @(negedge clk);
        seq_in = s; ack_in = a; flags_in = f; isn = i; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        fr = '0; act_bad = 0; busy_bad = 0; sent_at = -1; sent_cnt = 0;
        addr1 = '0; en1 = 1'b0;
        for (int k = 1; k <= 170; k++) begin
            @(negedge clk);
            if (k == 1) begin
                addr1 = mem_addr;
                en1   = mem_en;
            end
            if (k >= 10 && k < 154) fr = {fr[142:0], txbit};
            if (txactive !== (k >= 10 && k < 154)) act_bad++;
            if (busy !== (k <= 158)) busy_bad++;
            if (packetsent === 1'b1) begin
                sent_cnt++;
                sent_at = k;
            end
            start = inject && (k == 20);
            if (inject && k == 20) seq_in = 32'h00000099;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({txbit, txactive, packetsent, busy, mem_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {txbit, txactive, packetsent, busy, mem_en});
        end
        checks++;
        if (mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_mem_addr: got %h required 0000", mem_addr);
        end
        checks++;
        if ({txactive16, busy16, packetsent16} !== 3'b0) begin
            errors++;
            $display("FAIL reset_dut16: got %b required 000", {txactive16, busy16, packetsent16});
        end
    endtask

    task automatic test_data;
        logic [15:0] addr1; logic en1; logic [143:0] fr;
        int act_bad, busy_bad, sent_at, sent_cnt;
        run_b1(32'd5, 32'd3, 9'h010, 32'd0, 1'b0, addr1, en1, fr, act_bad, busy_bad,
               sent_at, sent_cnt);
        checks++;
        if (addr1 !== 16'd5 || en1 !== 1'b1) begin
            errors++;
            $display("FAIL data_fetch: got addr=%h en=%b required addr=0005 en=1", addr1, en1);
        end
        checks++;
        if (fr !== FRAME_DATA) begin
            errors++;
            $display("FAIL data_frame: got %h required %h", fr, FRAME_DATA);
        end
        checks++;
        if (act_bad != 0) begin
            errors++;
            $display("FAIL data_txactive: got %0d bad cycles required 0", act_bad);
        end
        checks++;
        if (sent_at != 158 || sent_cnt != 1) begin
            errors++;
            $display("FAIL data_packetsent: got at=%0d count=%0d required at=158 count=1",
                     sent_at, sent_cnt);
        end
    endtask

    task automatic test_syn;
        logic [15:0] addr1; logic en1; logic [143:0] fr; logic [143:0] exp;
        int act_bad, busy_bad, sent_at, sent_cnt;
        exp = {8'h55, 8'hD5, 32'h00001000, 32'h00002000, 16'h0002, 32'h0, 16'hCFFD};
        run_b1(32'h1000, 32'h2000, 9'h002, 32'd0, 1'b0, addr1, en1, fr, act_bad, busy_bad,
               sent_at, sent_cnt);
        checks++;
        if (en1 !== 1'b0) begin
            errors++;
            $display("FAIL syn_mem_en: got %b required 0", en1);
        end
        checks++;
        if (fr !== exp) begin
            errors++;
            $display("FAIL syn_frame: got %h required %h", fr, exp);
        end
        checks++;
        if (sent_at != 158 || sent_cnt != 1 || act_bad != 0) begin
            errors++;
            $display("FAIL syn_timing: got at=%0d count=%0d actbad=%0d required 158/1/0",
                     sent_at, sent_cnt, act_bad);
        end
    endtask

    task automatic test_flags_passthrough;
        logic [15:0] addr1; logic en1; logic [143:0] fr; logic [143:0] exp;
        int act_bad, busy_bad, sent_at, sent_cnt;
        exp = {8'h55, 8'hD5, 32'h5, 32'h3, 16'h01EC, 32'h12345678, 16'h955F};
        run_b1(32'd5, 32'd3, 9'h1EC, 32'd0, 1'b0, addr1, en1, fr, act_bad, busy_bad,
               sent_at, sent_cnt);
        checks++;
        if (fr !== exp || en1 !== 1'b1) begin
            errors++;
            $display("FAIL flags_frame: got %h en=%b required %h en=1", fr, en1, exp);
        end
    endtask

    task automatic test_busy_reject;
        logic [15:0] addr1; logic en1; logic [143:0] fr;
        int act_bad, busy_bad, sent_at, sent_cnt;
        run_b1(32'd5, 32'd3, 9'h010, 32'd0, 1'b1, addr1, en1, fr, act_bad, busy_bad,
               sent_at, sent_cnt);
        checks++;
        if (fr !== FRAME_DATA || act_bad != 0) begin
            errors++;
            $display("FAIL busy_frame: got %h actbad=%0d required %h actbad=0",
                     fr, act_bad, FRAME_DATA);
        end
        checks++;
        if (sent_cnt != 1 || sent_at != 158) begin
            errors++;
            $display("FAIL busy_packetsent: got count=%0d at=%0d required 1 at 158",
                     sent_cnt, sent_at);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL busy_level: got %0d bad cycles required 0", busy_bad);
        end
    endtask

    task automatic test_addr_wrap;
        logic [15:0] addr1; logic en1; logic [143:0] fr; logic [143:0] exp;
        int act_bad, busy_bad, sent_at, sent_cnt;
        exp = {8'h55, 8'hD5, 32'h2, 32'h0, 16'h0010, 32'hA5A50012, 16'h5A36};
        run_b1(32'h2, 32'h0, 9'h010, 32'hFFFFFFF0, 1'b0, addr1, en1, fr, act_bad, busy_bad,
               sent_at, sent_cnt);
        checks++;
        if (addr1 !== 16'h0012 || en1 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_addr: got addr=%h en=%b required addr=0012 en=1", addr1, en1);
        end
        checks++;
        if (fr !== exp) begin
            errors++;
            $display("FAIL wrap_frame: got %h required %h", fr, exp);
        end
    endtask

    task automatic test_reset_mid_send;
        logic [15:0] addr1; logic en1; logic [143:0] fr;
        int act_bad, busy_bad, sent_at, sent_cnt, stray;
        @(negedge clk);
        seq_in = 32'd5; ack_in = 32'h200; flags_in = 9'h010; isn = 32'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 80; k++) @(negedge clk);
        // Bit 70 is ack[9], which is set
        checks++;
        if (txbit !== 1'b1 || txactive !== 1'b1) begin
            errors++;
            $display("FAIL midsend_before: got txbit=%b txactive=%b required 1 1",
                     txbit, txactive);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({txbit, txactive, busy} !== 3'b000) begin
            errors++;
            $display("FAIL midsend_async_drop: got %b required 000", {txbit, txactive, busy});
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        stray = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (packetsent === 1'b1 || busy === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL midsend_no_sent: got %0d active cycles required 0", stray);
        end
        run_b1(32'd5, 32'd3, 9'h010, 32'd0, 1'b0, addr1, en1, fr, act_bad, busy_bad,
               sent_at, sent_cnt);
        checks++;
        if (fr !== FRAME_DATA || sent_at != 158 || sent_cnt != 1) begin
            errors++;
            $display("FAIL midsend_recover: got %h at=%0d count=%0d required %h at=158",
                     fr, sent_at, sent_cnt, FRAME_DATA);
        end
    endtask

    task automatic test_bit_hold_b2b;
        logic [143:0] exp;
        int hold_bad, act_bad, sent1, sent2, n_sent;
        bit in_f1, in_f2;
        exp = FRAME_DATA;
        hold_bad = 0; act_bad = 0; sent1 = -1; sent2 = -1; n_sent = 0;
        @(negedge clk);
        seq_in = 32'd5; ack_in = 32'd3; flags_in = 9'h010; isn = 32'd0; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        for (int k = 1; k <= 4650; k++) begin
            @(negedge clk);
            start16 = (k == 2319);
            in_f1 = (k >= 10) && (k < 2314);
            in_f2 = (k >= 2329) && (k < 4633);
            if (txactive16 !== (in_f1 || in_f2)) act_bad++;
            if (in_f1) begin
                if (txbit16 !== exp[143 - (k - 10) / 16]) hold_bad++;
            end else if (in_f2) begin
                if (txbit16 !== exp[143 - (k - 2329) / 16]) hold_bad++;
            end else if (txbit16 !== 1'b0) begin
                hold_bad++;
            end
            if (packetsent16 === 1'b1) begin
                n_sent++;
                if (sent1 < 0) sent1 = k;
                else sent2 = k;
            end
        end
        start16 = 1'b0;
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL hold_txbit: got %0d bad cycles required 0", hold_bad);
        end
        checks++;
        if (act_bad != 0) begin
            errors++;
            $display("FAIL hold_txactive: got %0d bad cycles required 0", act_bad);
        end
        checks++;
        if (sent1 != 2318 || sent2 != 4637 || n_sent != 2) begin
            errors++;
            $display("FAIL b2b_packetsent: got %0d/%0d n=%0d required 2318/4637 n=2",
                     sent1, sent2, n_sent);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; start16 = 1'b0;
        seq_in = '0; ack_in = '0; flags_in = '0; isn = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        test_data();
        test_syn();
        test_flags_passthrough();
        test_busy_reject();
        test_addr_wrap();
        test_reset_mid_send();
        test_bit_hold_b2b();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/packet_tx.md
Name: packet_tx

Overview:
Downstream transmit stage for the go-back-n connection controller. It accepts a one-cycle `start` pulse carrying SEQ, ACK and flags, and reads the payload word from data memory at address SEQ−ISN. It then builds a framed, checksummed packet and serialises it MSB-first onto the laser modulator line. When transmission and the inter-packet gap have finished, it returns a one-cycle `packetsent` pulse to the controller.

Parameters:
DATA_W, 32, payload width in bits; fixed at 32 for the 144-bit frame.
ADDR_W, 16, data memory address width.
BIT_CYCLES, 16, clk cycles each serial bit is held; must be ≥1.
GAP_CYCLES, 64, idle-low cycles after the last bit and before `packetsent`.

Ports:
clk  in  1  system clock (65 MHz).
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request to send a packet; driven by the controller's readyout.
seq_in  in  32  sequence number for this packet.
ack_in  in  32  acknowledgment number for this packet.
flags_in  in  9  flags; bit4=ACK, bit1=SYN, bit0=FIN.
isn  in  32  initial sequence number.
mem_addr  out  ADDR_W  data memory read address.
mem_en  out  1  data memory read enable.
mem_data  in  DATA_W  memory read data; valid exactly 1 cycle after mem_en.
txbit  out  1  serial line to the laser modulator; idle level 0.
txactive  out  1  high while frame bits are being driven.
packetsent  out  1  one-cycle pulse when the packet plus gap are complete.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: asynchronous on reset=0.
  - State returns to IDLE.
  - txbit, txactive, packetsent, busy, mem_en are all 0; mem_addr is 0.
  - All latches and counters clear.
  - Reset mid-frame aborts the frame; no `packetsent` is produced for it.
- States: IDLE → FETCH → CAPTURE → CSUM → SEND → GAP → DONE → IDLE.
- IDLE: on start=1, latch seq_in, ack_in, flags_in, isn.
  - `start` while not IDLE is ignored (no queueing).
- FETCH (1 cycle):
  - mem_addr = (seq − isn)[ADDR_W-1:0], 32-bit subtract with wrap.
  - mem_en = 1 only if SYN=0 and FIN=0; control packets do not read memory.
- CAPTURE (1 cycle): payload = mem_data for data packets, 32'h0 for SYN/FIN packets.
- CSUM (7 cycles): accumulate one 16-bit word per cycle, ones-complement (end-around carry).
  - Word order: seq[31:16], seq[15:0], ack[31:16], ack[15:0], {7'b0, flags}, payload[31:16], payload[15:0].
  - Checksum = bitwise NOT of the final sum.
- SEND: shift a 144-bit frame MSB-first; each bit is held BIT_CYCLES cycles; txactive=1 throughout.
  - Frame order: 8'h55 preamble, 8'hD5 SOF, seq[31:0], ack[31:0], {7'b0, flags}, payload[31:0], checksum[15:0].
- GAP: txbit=0, txactive=0 for GAP_CYCLES cycles.
- DONE: packetsent=1 for exactly one cycle, then return to IDLE.
  - A `start` arriving in the cycle after DONE is accepted.
- Latency, with start sampled at cycle t:
  - mem_en at t+1, capture at t+2, CSUM t+3..t+9.
  - First frame bit at t+10.
  - packetsent at t+10+144·BIT_CYCLES+GAP_CYCLES.
  - Timing is identical for data and control packets.
- Counters:
  - bit counter 0..143, 8 bits;
  - hold counter 0..BIT_CYCLES−1;
  - gap counter 0..GAP_CYCLES−1.
  - Widths come from $clog2 of these bounds; there is no wrap-around in any counter.
- Flags bits [8:5] and [3:2] pass through unchanged into the frame.

Decomposition:
- Shared package lasernet_pkg holds:
  - frame constants: PREAMBLE=8'h55, SOF=8'hD5, FRAME_BITS=144;
  - flag bit indices: FLAG_ACK=4, FLAG_SYN=1, FLAG_FIN=0;
  - the state enum.
- The upstream packet receiver reuses the same package for framing and checksum checking.
- One sub-module: ones_comp_csum16 (clear, add-word valid, 16-bit result). It is also instantiated by the receiver.

Test Plan:
- Data packet: reset released; isn=0, seq_in=5, ack_in=3, flags=9'h010; memory[5]=32'h12345678; BIT_CYCLES=1, GAP_CYCLES=4.
  - mem_addr=5 with mem_en=1 at t+1.
  - Captured frame: 55 D5 00000005 00000003 0010 12345678 973B.
  - packetsent pulses once at t+158.
- SYN packet: flags=9'h002.
  - mem_en stays 0; payload is 0.
  - checksum=~(seq16s+ack16s+0002); timing equal to the data case.
- Busy rejection: second start at t+20.
  - Ignored: only one frame is emitted and one packetsent pulse occurs; busy=1 from t+1 until packetsent.
- Address wrap: isn=32'hFFFFFFF0, seq_in=32'h00000002 → mem_addr=16'h0012.
- Async reset mid-SEND: reset=0 at bit 70.
  - txbit, txactive, busy drop immediately with no clock edge; no packetsent.
  - After release, a new start sends a complete frame.
- Bit hold and back-to-back: BIT_CYCLES=16.
  - Each bit is stable for exactly 16 cycles.
  - A start issued the cycle after packetsent begins the next frame at +10 cycles.
